// File: rtl/dft_scan_dump_sequencer.sv
// Scan-dump sequencer: walks the masked DFT scan chains in index order and
// funnels each chain's strobed words into the shared capture-buffer write port.

module dft_scan_dump_lane (
    input  logic        sel,
    input  logic        op_ack,
    input  logic        strobe,
    input  logic        commit,
    input  logic [31:0] data,
    output logic        op_ack_g,
    output logic        strobe_g,
    output logic        commit_g,
    output logic [31:0] data_g
);
    // Only the selected lane can reach the shared handshake/data buses.
    assign op_ack_g = sel & op_ack;
    assign strobe_g = sel & strobe;
    assign commit_g = sel & commit;
    assign data_g   = data & {32{sel}};
endmodule

module dft_scan_dump_sequencer #(
    parameter int p_sc_nbr          = 16,
    parameter int p_words_per_chain = 8,
    parameter int p_addr_width      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [p_sc_nbr-1:0]       chain_mask,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [3:0]                cur_chain,
    output logic [p_sc_nbr-1:0]       dft_val_op,
    input  logic [p_sc_nbr-1:0]       dft_op_ack,
    input  logic [p_sc_nbr-1:0]       dft_output_strobe,
    input  logic [32*p_sc_nbr-1:0]    dft_output_data,
    input  logic [p_sc_nbr-1:0]       dft_op_commit,
    output logic [p_sc_nbr-1:0]       dft_commit_ack,
    output logic                      buf_wen,
    output logic [p_addr_width-1:0]   buf_waddr,
    output logic [31:0]               buf_wdata
);
    localparam int IDX_W = $clog2(p_words_per_chain) + 1;

    typedef enum logic [2:0] {IDLE, SEL, REQ, CAPTURE, CACK, DONE} state_t;

    typedef struct packed {
        logic                    wen;
        logic [p_addr_width-1:0] addr;
        logic [31:0]             data;
    } wr_t;

    state_t              state_q, state_d;
    logic [p_sc_nbr-1:0] mask_q, mask_d;
    logic [4:0]          ptr_q, ptr_d;
    logic [3:0]          cur_chain_q, cur_chain_d;
    logic [IDX_W-1:0]    word_idx_q, word_idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;
    logic [p_sc_nbr-1:0] val_op_q, val_op_d;
    logic [p_sc_nbr-1:0] commit_ack_q, commit_ack_d;
    wr_t                 wr_q, wr_d;

    logic [p_sc_nbr-1:0]       lane_sel, lane_ack, lane_strobe, lane_commit;
    logic [p_sc_nbr-1:0][31:0] lane_data;
    logic                      ack_any, strobe_any, commit_any;
    logic [31:0]               data_any;
    logic                      sel_found;
    logic [3:0]                sel_idx;
    logic [p_addr_width-1:0]   wr_addr;

    generate
        for (genvar g = 0; g < p_sc_nbr; g++) begin : g_lane
            assign lane_sel[g] = (cur_chain_q == 4'(g));
            dft_scan_dump_lane u_lane (
                .sel      (lane_sel[g]),
                .op_ack   (dft_op_ack[g]),
                .strobe   (dft_output_strobe[g]),
                .commit   (dft_op_commit[g]),
                .data     (dft_output_data[32*g +: 32]),
                .op_ack_g (lane_ack[g]),
                .strobe_g (lane_strobe[g]),
                .commit_g (lane_commit[g]),
                .data_g   (lane_data[g])
            );
        end
    endgenerate

    assign ack_any    = |lane_ack;
    assign strobe_any = |lane_strobe;
    assign commit_any = |lane_commit;

    always_comb begin
        data_any = '0;
        for (int i = 0; i < p_sc_nbr; i++) data_any |= lane_data[i];
    end

    // Lowest masked chain at or above the pointer; descending scan keeps the lowest hit.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = p_sc_nbr - 1; i >= 0; i--) begin
            if (mask_q[i] && (5'(i) >= ptr_q)) begin
                sel_found = 1'b1;
                sel_idx   = 4'(i);
            end
        end
    end

    assign wr_addr = p_addr_width'(cur_chain_q) * p_addr_width'(p_words_per_chain)
                   + p_addr_width'(word_idx_q);

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        ptr_d       = ptr_q;
        cur_chain_d = cur_chain_q;
        word_idx_d  = word_idx_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;
        wr_d        = '0;

        if (state_q != IDLE && abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mask_d     = chain_mask;
                        overflow_d = 1'b0;
                        ptr_d      = '0;
                        state_d    = SEL;
                    end
                end
                SEL: begin
                    if (sel_found) begin
                        cur_chain_d = sel_idx;
                        state_d     = REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
                REQ: begin
                    if (ack_any) begin
                        word_idx_d = '0;
                        state_d    = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (strobe_any) begin
                        if (word_idx_q < IDX_W'(p_words_per_chain)) begin
                            wr_d.wen   = 1'b1;
                            wr_d.addr  = wr_addr;
                            wr_d.data  = data_any;
                            word_idx_d = word_idx_q + IDX_W'(1);
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    if (commit_any) state_d = CACK;
                end
                CACK: begin
                    ptr_d   = {1'b0, cur_chain_q} + 5'd1;
                    state_d = SEL;
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // busy stays up through the done pulse so it covers the whole dump.
        busy_d = (state_d != IDLE) || done_d;

        for (int i = 0; i < p_sc_nbr; i++) begin
            val_op_d[i]     = (state_d == REQ) && (cur_chain_d == 4'(i));
            commit_ack_d[i] = (state_q == CACK) && !abort && (cur_chain_q == 4'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            ptr_q        <= '0;
            cur_chain_q  <= '0;
            word_idx_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            val_op_q     <= '0;
            commit_ack_q <= '0;
            wr_q         <= '0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            ptr_q        <= ptr_d;
            cur_chain_q  <= cur_chain_d;
            word_idx_q   <= word_idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            val_op_q     <= val_op_d;
            commit_ack_q <= commit_ack_d;
            wr_q         <= wr_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign overflow       = overflow_q;
    assign cur_chain      = cur_chain_q;
    assign dft_val_op     = val_op_q;
    assign dft_commit_ack = commit_ack_q;
    assign buf_wen        = wr_q.wen;
    assign buf_waddr      = wr_q.addr;
    assign buf_wdata      = wr_q.data;

endmodule

// File: tb/tb_dft_scan_dump_sequencer.sv
// Directed bench for dft_scan_dump_sequencer: a negedge monitor logs bus
// activity, and each scenario task compares it against hand-computed values.

module tb_dft_scan_dump_sequencer;
    localparam int NC  = 16;
    localparam int WPC = 8;
    localparam int AW  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [NC-1:0]     chain_mask;
    logic              abort;
    logic              busy, done, overflow;
    logic [3:0]        cur_chain;
    logic [NC-1:0]     dft_val_op, dft_op_ack, dft_output_strobe, dft_op_commit, dft_commit_ack;
    logic [32*NC-1:0]  dft_output_data;
    logic              buf_wen;
    logic [AW-1:0]     buf_waddr;
    logic [31:0]       buf_wdata;

    always #5 clk = ~clk;

    dft_scan_dump_sequencer #(.p_sc_nbr(NC), .p_words_per_chain(WPC), .p_addr_width(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .chain_mask(chain_mask), .abort(abort),
        .busy(busy), .done(done), .overflow(overflow), .cur_chain(cur_chain),
        .dft_val_op(dft_val_op), .dft_op_ack(dft_op_ack), .dft_output_strobe(dft_output_strobe),
        .dft_output_data(dft_output_data), .dft_op_commit(dft_op_commit),
        .dft_commit_ack(dft_commit_ack), .buf_wen(buf_wen), .buf_waddr(buf_waddr),
        .buf_wdata(buf_wdata)
    );

    int            n_cmp = 0;
    int            n_err = 0;
    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    int            cack_log[$];
    int            vo_chain[$];
    logic [NC-1:0] vo_seen;
    logic [NC-1:0] prev_vo;
    int            done_cnt;

    always @(negedge clk) begin
        if (buf_wen === 1'b1) begin
            wr_addr.push_back(buf_waddr);
            wr_data.push_back(buf_wdata);
        end
        for (int i = 0; i < NC; i++) begin
            if (dft_commit_ack[i] === 1'b1) cack_log.push_back(i);
        end
        vo_seen = vo_seen | dft_val_op;
        if (dft_val_op != '0 && prev_vo == '0) vo_chain.push_back(int'(cur_chain));
        prev_vo = dft_val_op;
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_log();
        wr_addr.delete();
        wr_data.delete();
        cack_log.delete();
        vo_chain.delete();
        vo_seen  = '0;
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [NC-1:0] m);
        chain_mask = m;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_val_op(input int ch, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (dft_val_op[ch] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Plays one chain: ack after ack_dly cycles, nw strobed words, then commit.
    task automatic serve_chain(input int ch, input int nw, input logic [31:0] base,
                               input int ack_dly, output bit ok);
        wait_val_op(ch, ok);
        if (!ok) return;
        repeat (ack_dly) tick();
        dft_op_ack[ch] = 1'b1;
        tick();
        dft_op_ack[ch] = 1'b0;
        for (int w = 0; w < nw; w++) begin
            dft_output_strobe[ch] = 1'b1;
            dft_output_data[32*ch +: 32] = base + 32'(w);
            tick();
        end
        dft_output_strobe[ch] = 1'b0;
        dft_op_commit[ch] = 1'b1;
        tick();
        dft_op_commit[ch] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; chain_mask = '0; abort = 1'b0;
        dft_op_ack = '0; dft_output_strobe = '0; dft_op_commit = '0; dft_output_data = '0;
        prev_vo = '0;
        clr_log();
        repeat (2) tick();
        n_cmp++; if ({busy, done, overflow, buf_wen} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {busy, done, overflow, buf_wen}); end
        n_cmp++; if (cur_chain !== 4'd0) begin n_err++; $display("FAIL reset_cur_chain: got %0d want 0", cur_chain); end
        n_cmp++; if ({dft_val_op, dft_commit_ack} !== '0) begin n_err++; $display("FAIL reset_handshake: got %h want 0", {dft_val_op, dft_commit_ack}); end
        n_cmp++; if ({buf_waddr, buf_wdata} !== '0) begin n_err++; $display("FAIL reset_wport: got %h want 0", {buf_waddr, buf_wdata}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        clr_log();
        do_start(16'h0004);
        serve_chain(2, 3, 32'hA0, 2, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL single_val_op_timeout: got %b want 1", ok); end
        tick();
        n_cmp++; if (dft_commit_ack !== 16'h0004) begin n_err++; $display("FAIL single_cack: got %h want 0004", dft_commit_ack); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL single_done_early1: got %b want 0", done); end
        tick();
        n_cmp++; if ({dft_commit_ack, done} !== 17'h0) begin n_err++; $display("FAIL single_cack_len: got %h want 0", {dft_commit_ack, done}); end
        tick();
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL single_done: got %b want 1", done); end
        tick();
        n_cmp++; if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL single_idle: got %b want 00", {done, busy}); end
        n_cmp++; if (wr_addr.size() !== 3) begin n_err++; $display("FAIL single_wr_count: got %0d want 3", wr_addr.size()); end
        if (wr_addr.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (wr_addr[i] !== AW'(16 + i)) begin n_err++; $display("FAIL single_addr%0d: got %0d want %0d", i, wr_addr[i], 16 + i); end
                n_cmp++; if (wr_data[i] !== 32'hA0 + 32'(i)) begin n_err++; $display("FAIL single_data%0d: got %h want %h", i, wr_data[i], 32'hA0 + 32'(i)); end
            end
        end
        n_cmp++; if (cack_log.size() !== 1 || cack_log[0] !== 2) begin n_err++; $display("FAIL single_cack_log: got size %0d want one ack on chain 2", cack_log.size()); end
    endtask

    task automatic test_multi_order();
        bit ok0, ok8, ok15, oki;
        int exp_ch[3];
        logic [AW-1:0] exp_ad[3];
        exp_ch = '{0, 8, 15};
        exp_ad = '{8'd0, 8'd64, 8'd120};
        clr_log();
        do_start(16'h8101);
        serve_chain(0, 1, 32'h100, 1, ok0);
        serve_chain(8, 1, 32'h108, 0, ok8);
        serve_chain(15, 1, 32'h10F, 3, ok15);
        wait_idle(oki);
        n_cmp++; if ({ok0, ok8, ok15, oki} !== 4'b1111) begin n_err++; $display("FAIL multi_timeout: got %b want 1111", {ok0, ok8, ok15, oki}); end
        n_cmp++; if (wr_addr.size() !== 3 || cack_log.size() !== 3 || vo_chain.size() !== 3) begin n_err++; $display("FAIL multi_counts: got wr %0d cack %0d sel %0d want 3 3 3", wr_addr.size(), cack_log.size(), vo_chain.size()); end
        if (wr_addr.size() == 3 && cack_log.size() == 3 && vo_chain.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (wr_addr[i] !== exp_ad[i]) begin n_err++; $display("FAIL multi_addr%0d: got %0d want %0d", i, wr_addr[i], exp_ad[i]); end
                n_cmp++; if (wr_data[i] !== 32'h100 + 32'(exp_ch[i])) begin n_err++; $display("FAIL multi_data%0d: got %h want %h", i, wr_data[i], 32'h100 + 32'(exp_ch[i])); end
                n_cmp++; if (cack_log[i] !== exp_ch[i]) begin n_err++; $display("FAIL multi_cack%0d: got %0d want %0d", i, cack_log[i], exp_ch[i]); end
                n_cmp++; if (vo_chain[i] !== exp_ch[i]) begin n_err++; $display("FAIL multi_cur_chain%0d: got %0d want %0d", i, vo_chain[i], exp_ch[i]); end
            end
        end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL multi_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_empty_mask();
        clr_log();
        do_start(16'h0000);
        n_cmp++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL empty_c1: got %b want 10", {busy, done}); end
        tick();
        n_cmp++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL empty_c2: got %b want 10", {busy, done}); end
        tick();
        n_cmp++; if ({busy, done} !== 2'b11) begin n_err++; $display("FAIL empty_c3: got %b want 11", {busy, done}); end
        tick();
        n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL empty_c4: got %b want 00", {busy, done}); end
        n_cmp++; if (vo_seen !== '0) begin n_err++; $display("FAIL empty_val_op: got %h want 0", vo_seen); end
    endtask

    task automatic test_overflow();
        bit ok, oki;
        clr_log();
        do_start(16'h0001);
        wait_val_op(0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL ovf_val_op_timeout: got %b want 1", ok); end
        dft_op_ack[0] = 1'b1;
        tick();
        dft_op_ack[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            dft_output_strobe[0] = 1'b1;
            dft_output_data[31:0] = 32'h200 + 32'(i);
            tick();
            if (i == 7) begin
                n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_after8: got %b want 0", overflow); end
            end
            if (i == 8) begin
                n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_after9: got %b want 1", overflow); end
            end
        end
        dft_output_strobe[0] = 1'b0;
        dft_op_commit[0] = 1'b1;
        tick();
        dft_op_commit[0] = 1'b0;
        wait_idle(oki);
        n_cmp++; if ({oki, overflow} !== 2'b11) begin n_err++; $display("FAIL ovf_sticky: got %b want 11", {oki, overflow}); end
        n_cmp++; if (wr_addr.size() !== 8) begin n_err++; $display("FAIL ovf_wr_count: got %0d want 8", wr_addr.size()); end
        if (wr_addr.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++; if (wr_addr[i] !== AW'(i) || wr_data[i] !== 32'h200 + 32'(i)) begin n_err++; $display("FAIL ovf_wr%0d: got %0d/%h want %0d/%h", i, wr_addr[i], wr_data[i], i, 32'h200 + 32'(i)); end
            end
        end
        do_start(16'h0000);
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        wait_idle(oki);
    endtask

    task automatic test_abort();
        bit ok;
        clr_log();
        do_start(16'h0018);
        wait_val_op(3, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL abort_val_op_timeout: got %b want 1", ok); end
        dft_op_ack[3] = 1'b1;
        tick();
        dft_op_ack[3] = 1'b0;
        dft_output_strobe[3] = 1'b1;
        dft_output_data[32*3 +: 32] = 32'h300;
        tick();
        dft_output_data[32*3 +: 32] = 32'h301;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        dft_output_strobe[3] = 1'b0;
        n_cmp++; if ({busy, done, buf_wen} !== 3'b000 || dft_val_op !== '0) begin n_err++; $display("FAIL abort_next: got %b/%h want 000/0", {busy, done, buf_wen}, dft_val_op); end
        repeat (10) tick();
        n_cmp++; if (vo_seen[4] !== 1'b0) begin n_err++; $display("FAIL abort_chain4: got %b want 0", vo_seen[4]); end
        n_cmp++; if (done_cnt !== 0 || cack_log.size() !== 0) begin n_err++; $display("FAIL abort_done: got %0d/%0d want 0/0", done_cnt, cack_log.size()); end
        n_cmp++; if (wr_addr.size() !== 1 || wr_addr[0] !== 8'd24 || wr_data[0] !== 32'h300) begin n_err++; $display("FAIL abort_writes: got %0d writes want 1 at 24", wr_addr.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clr_log();
        do_start(16'h0004);
        wait_val_op(2, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rstmid_val_op_timeout: got %b want 1", ok); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({busy, done, overflow, buf_wen, cur_chain} !== 8'h00 || dft_val_op !== '0 || dft_commit_ack !== '0) begin n_err++; $display("FAIL rstmid_async: got %b/%h want 0", {busy, done, overflow, buf_wen, cur_chain}, dft_val_op); end
        tick();
        reset = 1'b0;
        repeat (3) tick();
        n_cmp++; if ({busy, done_cnt != 0} !== 2'b00) begin n_err++; $display("FAIL rstmid_after: got busy %b done %0d want 0 0", busy, done_cnt); end
    endtask

    task automatic test_interference();
        bit ok, oki;
        clr_log();
        do_start(16'h0002);
        dft_op_ack[5] = 1'b1;
        dft_output_strobe[5] = 1'b1;
        dft_op_commit[5] = 1'b1;
        dft_output_data[32*5 +: 32] = 32'hDEAD;
        do_start(16'hFFFF);
        serve_chain(1, 1, 32'h55, 1, ok);
        wait_idle(oki);
        dft_op_ack[5] = 1'b0;
        dft_output_strobe[5] = 1'b0;
        dft_op_commit[5] = 1'b0;
        n_cmp++; if ({ok, oki} !== 2'b11) begin n_err++; $display("FAIL intf_timeout: got %b want 11", {ok, oki}); end
        n_cmp++; if (vo_seen !== 16'h0002) begin n_err++; $display("FAIL intf_val_op: got %h want 0002", vo_seen); end
        n_cmp++; if (wr_addr.size() !== 1 || wr_addr[0] !== 8'd8 || wr_data[0] !== 32'h55) begin n_err++; $display("FAIL intf_writes: got %0d writes want 1 at 8 data 55", wr_addr.size()); end
        n_cmp++; if (cack_log.size() !== 1 || cack_log[0] !== 1) begin n_err++; $display("FAIL intf_cack: got %0d acks want one on chain 1", cack_log.size()); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL intf_done: got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_order();
        test_empty_mask();
        test_overflow();
        test_abort();
        test_reset_mid();
        test_interference();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dft_scan_dump_sequencer.md
Name: dft_scan_dump_sequencer

Overview:
- Sequences scan-chain dumps from up to p_sc_nbr DFT scan chains into the prewrapper capture buffer.
- The capture buffer has one shared 32-bit write port; this block arbitrates that port between chains.
- Chains are served one at a time, in increasing index order, under a software-supplied chain mask.
- Drives the per-chain val_op / op_ack / op_commit / commit_ack handshake and generates buffer write address, data and enable.

Parameters:
p_sc_nbr, 16, number of scan chains (1..16)
p_words_per_chain, 8, buffer slots reserved per chain (power of 2)
p_addr_width, 8, capture-buffer address width

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle dump request; sampled only in IDLE
chain_mask  input  p_sc_nbr  chains to dump; sampled with start
abort  input  1  terminates an in-progress dump
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when all masked chains are committed
overflow  output  1  sticky; set when a chain strobes more than p_words_per_chain words; cleared by start
cur_chain  output  4  index of the chain being served
dft_val_op  output  p_sc_nbr  one-hot operation request to the selected chain
dft_op_ack  input  p_sc_nbr  chain accepts request
dft_output_strobe  input  p_sc_nbr  chain presents a valid data word
dft_output_data  input  32*p_sc_nbr  per-chain data; chain i uses bits [32i+31:32i]
dft_op_commit  input  p_sc_nbr  chain finished shifting out
dft_commit_ack  output  p_sc_nbr  one-cycle acknowledge of commit
buf_wen  output  1  capture-buffer write enable
buf_waddr  output  p_addr_width  capture-buffer write address
buf_wdata  output  32  capture-buffer write data

Behaviour:
- Reset: state IDLE; all outputs 0, including overflow and cur_chain. Reset mid-dump aborts immediately; no done and no commit_ack are issued.
- All outputs are registered.
- FSM states: IDLE, SEL, REQ, CAPTURE, CACK, DONE.
- IDLE:
  - start=1 latches chain_mask, clears overflow, sets pointer to 0, and goes to SEL.
  - start while busy is ignored.
- SEL (1 cycle):
  - Finds the lowest set mask bit at index >= pointer and loads cur_chain with it; goes to REQ.
  - If no such bit exists, goes to DONE.
  - A mask of 0 therefore gives done exactly 3 cycles after start, with no val_op.
- REQ:
  - dft_val_op[cur_chain]=1; all other val_op bits are 0.
  - Held until dft_op_ack[cur_chain]=1 is sampled.
  - val_op is 0 in the following cycle; state goes to CAPTURE and word_idx is cleared.
- CAPTURE:
  - On each cycle with dft_output_strobe[cur_chain]=1 and word_idx < p_words_per_chain, the next cycle has:
    - buf_wen=1
    - buf_wdata = that chain's data word
    - buf_waddr = cur_chain*p_words_per_chain + word_idx, truncated to p_addr_width
  - word_idx then increments.
  - Strobes with word_idx == p_words_per_chain write nothing and set overflow.
  - dft_op_commit[cur_chain]=1 goes to CACK. A strobe in the same cycle as the commit is still written.
- CACK (1 cycle):
  - dft_commit_ack[cur_chain]=1 for exactly one cycle.
  - pointer = cur_chain+1; state goes to SEL.
- DONE (1 cycle): done=1, then IDLE.
- Handshake inputs from chains other than cur_chain are ignored in every state.
- Write port: buf_wen is never high for two chains in the same cycle, and never high outside the cycle after a CAPTURE strobe.
- abort:
  - Takes priority over all transitions in any non-IDLE state.
  - Next cycle: IDLE, with val_op, commit_ack and buf_wen all 0 and no done.
  - A strobe in the abort cycle is not written.
- pointer wraps are impossible: SEL terminates at index p_sc_nbr-1.

Test Plan:
- Single chain: mask=0x0004; ack 2 cycles after val_op; 3 strobes with data 0xA0,0xA1,0xA2; then commit.
  -> buf writes to addr 16,17,18; commit_ack[2] for 1 cycle; done pulses 2 cycles after commit_ack.
- Multi-chain order: mask=0x8101; each chain strobes 1 word.
  -> service order 0,8,15; addresses 0,64,120; cur_chain sequence 0,8,15; exactly 3 commit_acks.
- Empty mask: start with mask=0.
  -> no val_op; done=1 exactly 3 cycles after start; busy high for 3 cycles.
- Overflow: mask=0x0001; 10 strobes before commit.
  -> 8 writes to addr 0..7; overflow=1 after the 9th strobe and held until the next start.
- Abort and reset: abort in CAPTURE of chain 3 (mask=0x0018).
  -> IDLE next cycle; chain 4 never sees val_op; no done. Separately, reset asserted in REQ -> all outputs 0 asynchronously.
- Interference: strobes/commits on chain 5 while serving chain 1 (mask=0x0002).
  -> no writes or commit_ack for chain 5; a start pulse while busy is ignored.
